// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared constants and the period/duty timing helper for led_pwm_fader.
package led_pwm_pkg;

  localparam logic c_filament_on_value  = 1'b1;
  localparam logic c_filament_off_value = 1'b0;

  typedef struct packed {
    int unsigned period_clks;  // clocks per PWM period
    int unsigned max_clks;     // on-clocks at full level
    int unsigned step_clks;    // on-clocks added per level step
  } t_pwm_timing;

  function automatic t_pwm_timing calc_timing(
    input int unsigned fclk,
    input int unsigned period_ms,
    input int unsigned max_pct,
    input int unsigned level_bits
  );
    t_pwm_timing t;
    t.period_clks = fclk / 32'd1000 * period_ms;
    t.max_clks    = t.period_clks / 32'd100 * max_pct;
    t.step_clks   = t.max_clks / ((32'd1 << level_bits) - 32'd1);
    return t;
  endfunction

endpackage

// File: rtl/led_pwm_fader_chan.sv
// led_pwm_fader_chan: one PWM channel - target/step/level/duty registers and the on-time comparator.
// Fading is built only when LED_PWM_FADER_FADE_EN is defined; otherwise the level jumps to the
// target at every period boundary and the step input is ignored.
module led_pwm_fader_chan
  import led_pwm_pkg::*;
#(
  parameter int unsigned parm_level_bits = 8,
  parameter int unsigned parm_cnt_bits   = 16,
  parameter int unsigned parm_step_clks  = 1
) (
  input  logic                       i_clk,
  input  logic                       i_arstn,
  input  logic                       i_boundary,
  input  logic                       i_load_en,
  input  logic [parm_level_bits-1:0] i_load_level,
  input  logic [parm_level_bits-1:0] i_load_step,
  input  logic [parm_cnt_bits-1:0]   i_cnt,
  output logic                       o_pwm,
  output logic                       o_fade_busy
);

  typedef logic [parm_level_bits-1:0] t_level;
  typedef logic [parm_cnt_bits-1:0]   t_duty;

  t_level target_q, target_d;
  t_level level_q, level_d;
  t_level step_eff;
  t_duty  duty_q, duty_d;
  logic   pwm_q, pwm_d;
  logic   busy_q, busy_d;

`ifdef LED_PWM_FADER_FADE_EN
  t_level step_q, step_d;

  // Fade step is captured together with the target on every accepted load.
  always_comb begin
    step_d = step_q;
    if (i_load_en) step_d = i_load_step;
  end

  // Step register.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) step_q <= '0;
    else          step_q <= step_d;
  end

  assign step_eff = step_q;
`else
  logic unused_step;
  assign unused_step = ^i_load_step;
  assign step_eff    = '0;
`endif

  // Target capture, boundary level move (clamped at the target), duty product and comparator.
  always_comb begin
    target_d = target_q;
    level_d  = level_q;
    if (i_load_en) target_d = i_load_level;
    if (i_boundary) begin
      if (step_eff == '0) begin
        level_d = target_q;
      end else if (target_q > level_q) begin
        level_d = ((target_q - level_q) > step_eff) ? level_q + step_eff : target_q;
      end else if (target_q < level_q) begin
        level_d = ((level_q - target_q) > step_eff) ? level_q - step_eff : target_q;
      end
    end
    duty_d = t_duty'(level_q * parm_step_clks);
    // The boundary (count 0) is always dark, so counts 1..duty give exactly duty on-cycles.
    pwm_d = c_filament_off_value;
    if (!i_boundary && (i_cnt <= duty_q)) pwm_d = c_filament_on_value;
    busy_d = (level_q != target_q);
  end

  // Channel state registers; reset forces the output dark immediately.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      target_q <= '0;
      level_q  <= '0;
      duty_q   <= '0;
      pwm_q    <= c_filament_off_value;
      busy_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      level_q  <= level_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      busy_q   <= busy_d;
    end
  end

  assign o_pwm       = pwm_q;
  assign o_fade_busy = busy_q;

endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: multi-channel LED PWM driver with a shared down-counting period counter,
// load decode/ready logic and one led_pwm_fader_chan per channel.
// Optional feature macro: LED_PWM_FADER_FADE_EN (per-channel linear fading toward the target).
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter int unsigned parm_chan_count              = 8,
  parameter int unsigned parm_level_bits              = 8,
  parameter int unsigned parm_FCLK                    = 40_000_000,
  parameter int unsigned parm_pwm_period_milliseconds = 10,
  parameter int unsigned parm_max_duty_pct            = 80,
  localparam int unsigned c_chan_bits = (parm_chan_count > 1) ? $clog2(parm_chan_count) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_arstn,
  input  logic                       i_load_valid,
  output logic                       o_load_ready,
  input  logic [c_chan_bits-1:0]     i_load_chan,
  input  logic [parm_level_bits-1:0] i_load_level,
  input  logic [parm_level_bits-1:0] i_load_step,
  output logic [parm_chan_count-1:0] o_pwm,
  output logic [parm_chan_count-1:0] o_fade_busy,
  output logic                       o_period_strobe
);

  localparam t_pwm_timing c_timing = calc_timing(parm_FCLK, parm_pwm_period_milliseconds,
                                                 parm_max_duty_pct, parm_level_bits);
  localparam int unsigned c_period_clks = c_timing.period_clks;
  localparam int unsigned c_max_clks    = c_timing.max_clks;
  localparam int unsigned c_step_clks   = c_timing.step_clks;
  localparam int unsigned c_cnt_bits    = $clog2(c_period_clks);
  localparam logic [c_cnt_bits-1:0] c_cnt_reload = c_cnt_bits'(c_period_clks - 1);

  if (c_step_clks < 1 || c_max_clks >= c_period_clks) begin : g_timing_check
    $error("led_pwm_fader: level resolution too fine for the PWM period, or full duty reaches the boundary");
  end

  logic [c_cnt_bits-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  strobe_q, strobe_d;
  logic                  boundary;
  logic                  load_accept;

  assign boundary    = (cnt_q == '0);
  assign load_accept = i_load_valid && ready_q;

  // Period counter reload; ready is precomputed so it is low exactly in the boundary cycle.
  always_comb begin
    cnt_d = cnt_q - c_cnt_bits'(1);
    if (boundary) cnt_d = c_cnt_reload;
    ready_d  = (cnt_d != '0);
    strobe_d = boundary;
  end

  // Shared period counter, load-ready and period strobe registers.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      cnt_q    <= c_cnt_reload;
      ready_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      strobe_q <= strobe_d;
    end
  end

  assign o_load_ready    = ready_q;
  assign o_period_strobe = strobe_q;

  // Indices with no matching channel match no decode term and are silently dropped.
  for (genvar gi = 0; gi < parm_chan_count; gi++) begin : g_chan
    logic load_en;
    assign load_en = load_accept && (i_load_chan == c_chan_bits'(gi));

    led_pwm_fader_chan #(
      .parm_level_bits (parm_level_bits),
      .parm_cnt_bits   (c_cnt_bits),
      .parm_step_clks  (c_step_clks)
    ) u_chan (
      .i_clk        (i_clk),
      .i_arstn      (i_arstn),
      .i_boundary   (boundary),
      .i_load_en    (load_en),
      .i_load_level (i_load_level),
      .i_load_step  (i_load_step),
      .i_cnt        (cnt_q),
      .o_pwm        (o_pwm[gi]),
      .o_fade_busy  (o_fade_busy[gi])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: randomized + directed stimulus against a per-period level model.
// Expected on-cycle counts and end-of-period busy flags are queued by the driver and
// checked by a monitor that closes one window per o_period_strobe.
`timescale 1ns/1ps
module tb_led_pwm_fader;

  localparam int NCH    = 4;
  localparam int W      = 4;
  localparam int PERIOD = 100;  // 100 kHz, 1 ms
  localparam int STEPC  = 5;    // 80 on-clocks / 15 levels

  logic           clk = 1'b0;
  logic           arstn = 1'b0;
  logic           load_valid = 1'b0;
  logic           load_ready;
  logic [1:0]     load_chan = '0;
  logic [W-1:0]   load_level = '0;
  logic [W-1:0]   load_step = '0;
  logic [NCH-1:0] pwm;
  logic [NCH-1:0] busy;
  logic           strobe;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .parm_chan_count              (NCH),
    .parm_level_bits              (W),
    .parm_FCLK                    (100_000),
    .parm_pwm_period_milliseconds (1),
    .parm_max_duty_pct            (80)
  ) dut (
    .i_clk           (clk),
    .i_arstn         (arstn),
    .i_load_valid    (load_valid),
    .o_load_ready    (load_ready),
    .i_load_chan     (load_chan),
    .i_load_level    (load_level),
    .i_load_step     (load_step),
    .o_pwm           (pwm),
    .o_fade_busy     (busy),
    .o_period_strobe (strobe)
  );

  typedef struct packed {
    logic [NCH-1:0][7:0] on_cnt;
    logic [NCH-1:0]      busy;
  } exp_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   n;                 // clock edges since reset release
  int   m_tgt[NCH];
  int   m_stp[NCH];
  int   m_lvl[NCH];
  exp_t sb[$];

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Linear fade: move toward the target by the step, never past it; step 0 jumps.
  function automatic int move_toward(input int lvl, input int tgt, input int stp);
    int diff;
    if (stp == 0) return tgt;
    diff = (tgt > lvl) ? tgt - lvl : lvl - tgt;
    if (diff <= stp) return tgt;
    return (tgt > lvl) ? lvl + stp : lvl - stp;
  endfunction

  task automatic reset_model();
    for (int c = 0; c < NCH; c++) begin
      m_tgt[c] = 0;
      m_stp[c] = 0;
      m_lvl[c] = 0;
    end
    sb.delete();
    n = 0;
  endtask

  // One clock cycle: drive inputs, check ready/strobe, update the model, advance.
  task automatic cyc(input bit v, input int ch, input int lv, input int st, output bit acc);
    bit   rdy_exp;
    exp_t e;
    load_valid = v;
    load_chan  = ch[1:0];
    load_level = lv[W-1:0];
    load_step  = st[W-1:0];
    rdy_exp = (n >= 1) && (n % PERIOD != PERIOD - 1);
    check("load_ready", int'(load_ready), rdy_exp ? 1 : 0);
    check("period_strobe", int'(strobe), (n >= PERIOD && n % PERIOD == 0) ? 1 : 0);
    // Two cycles before a window closes, its expectation is fixed.
    if (n >= 2 * PERIOD - 2 && n % PERIOD == PERIOD - 2) begin
      for (int c = 0; c < NCH; c++) begin
        e.on_cnt[c] = 8'(m_lvl[c] * STEPC);
        e.busy[c]   = (m_lvl[c] != m_tgt[c]);
      end
      sb.push_back(e);
    end
    acc = v && rdy_exp;
    if (acc && ch < NCH) begin
      m_tgt[ch] = lv;
`ifdef LED_PWM_FADER_FADE_EN
      m_stp[ch] = st;
`else
      m_stp[ch] = 0;
`endif
    end
    if (n % PERIOD == PERIOD - 1) begin
      for (int c = 0; c < NCH; c++) m_lvl[c] = move_toward(m_lvl[c], m_tgt[c], m_stp[c]);
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic load(input int ch, input int lv, input int st);
    bit acc;
    acc = 1'b0;
    while (!acc) cyc(1'b1, ch, lv, st, acc);
  endtask

  task automatic idle(input int k);
    bit acc;
    repeat (k) cyc(1'b0, 0, 0, 0, acc);
  endtask

  task automatic to_offset(input int o);
    while (n % PERIOD != o) idle(1);
  endtask

  // Monitor: count on-cycles per strobe-to-strobe window and compare with the queue.
  initial begin : monitor
    bit             in_win;
    int             len;
    int             cnt[NCH];
    logic [NCH-1:0] busy_last;
    exp_t           e;
    in_win    = 1'b0;
    len       = 0;
    busy_last = '0;
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    forever begin
      @(negedge clk);
      if (!arstn) begin
        in_win = 1'b0;
      end else begin
        if (strobe) begin
          if (in_win) begin
            check("period_length", len, PERIOD);
            if (sb.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL window_expectation: got a closed period, expected none pending (t=%0t)", $time);
            end else begin
              e = sb.pop_front();
              for (int c = 0; c < NCH; c++)
                check($sformatf("on_cycles_ch%0d", c), cnt[c], int'(e.on_cnt[c]));
              check("fade_busy_end_of_period", int'(busy_last), int'(e.busy));
            end
          end
          in_win = 1'b1;
          len    = 0;
          for (int c = 0; c < NCH; c++) cnt[c] = 0;
        end
        if (in_win) begin
          len++;
          for (int c = 0; c < NCH; c++) cnt[c] += int'(pwm[c]);
          busy_last = busy;
        end
      end
    end
  end

  initial begin : driver
    reset_model();
    arstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pwm", int'(pwm), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_strobe", int'(strobe), 0);
    check("reset_ready", int'(load_ready), 0);
    arstn = 1'b1;
    reset_model();

    // Full level, jump.
    to_offset(10);
    load(0, 15, 0);
    idle(3 * PERIOD);
    // Fade up 0 -> 10 by 3.
    load(1, 10, 3);
    idle(5 * PERIOD);
    // Fade down 10 -> 2 by 4, then dark.
    load(1, 2, 4);
    idle(3 * PERIOD);
    load(1, 0, 0);
    idle(2 * PERIOD);
    // Valid held continuously across a boundary; one load stalls, none is lost.
    to_offset(95);
    for (int i = 1; i <= 8; i++) load(3, i, 0);
    idle(2 * PERIOD);
    // Two loads to one channel in one period: the last wins.
    // With four channels the 2-bit index has no out-of-range value to exercise.
    to_offset(20);
    load(2, 5, 0);
    load(2, 12, 0);
    idle(2 * PERIOD);
    // Random loads.
    repeat (8 * PERIOD) begin
      if ($urandom_range(0, 19) == 0)
        load(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      else
        idle(1);
    end
    idle(6 * PERIOD);
    // All channels bright, then asynchronous reset mid-period.
    for (int c = 0; c < NCH; c++) load(c, 15, 0);
    idle(2 * PERIOD);
    to_offset(50);
    load_valid = 1'b0;
    #2 arstn = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_strobe", int'(strobe), 0);
    check("async_reset_ready", int'(load_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("held_reset_pwm", int'(pwm), 0);
    arstn = 1'b1;
    reset_model();
    idle(4 * PERIOD);
    to_offset(50);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
